// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int DEF_NUM_PORTS      = 2;
  localparam int DEF_PKT_BYTES      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick: first requesting port after last_served, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_served,
  output logic [NUM_PORTS-1:0] pick
);

  logic found;

  // Scan candidates in priority order last_served+1, +2, ... and keep the first hit.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!found && req[j] && ((int'(last_served) + i) % NUM_PORTS == j)) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_PORTS byte requesters, locking the
// grant for a packet of PKT_BYTES bytes or until the owner goes idle too long.
//
//   state | meaning
//   IDLE  | no owner; pick a full holding register round-robin
//   LOAD  | one cycle: strobe owner's byte to the transmitter, free its holder
//   WAIT  | byte in flight; wait for uart_tx_value_done
//   HOLD  | packet open; wait for owner's next byte or time out
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS      = DEF_NUM_PORTS,
  parameter int PKT_BYTES      = DEF_PKT_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clock,
  input  logic                      arst,
  input  logic [NUM_PORTS-1:0][7:0] req_value,
  input  logic [NUM_PORTS-1:0]      req_write,
  output logic [NUM_PORTS-1:0]      req_done,
  output logic [NUM_PORTS-1:0]      req_overrun,
  output logic [NUM_PORTS-1:0]      grant,
  output logic [7:0]                uart_tx_value,
  output logic                      uart_tx_value_write,
  input  logic                      uart_tx_value_done,
  output logic                      timeout_pulse
);

  localparam int IDX_W = cnt_w(NUM_PORTS);
  localparam int BC_W  = cnt_w(PKT_BYTES);
  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);

  state_t                      state, state_nxt;
  logic [NUM_PORTS-1:0]        hold_full;
  logic [NUM_PORTS-1:0][7:0]   hold_data;
  logic [IDX_W-1:0]            grant_idx, pick_idx, last_served, load_idx;
  logic [BC_W-1:0]             byte_cnt;
  logic [TO_W-1:0]             tmo_cnt;
  logic [NUM_PORTS-1:0]        pick;
  logic                        take, release_grant, bc_inc, tmo_clr, tmo_inc, load_enter;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req         (hold_full),
    .last_served (last_served),
    .pick        (pick)
  );

  // Binary index of the one-hot round-robin pick.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign load_idx = (state == ST_IDLE) ? pick_idx : grant_idx;

  // FSM state register.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and strobes; outputs decode from state so reset silences them at once.
  always_comb begin
    state_nxt           = state;
    req_done            = '0;
    timeout_pulse       = 1'b0;
    uart_tx_value_write = 1'b0;
    take                = 1'b0;
    release_grant       = 1'b0;
    bc_inc              = 1'b0;
    tmo_clr             = 1'b0;
    tmo_inc             = 1'b0;
    load_enter          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|hold_full) begin
          take       = 1'b1;
          load_enter = 1'b1;
          state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        uart_tx_value_write = 1'b1;
        state_nxt           = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart_tx_value_done) begin
          req_done = grant;
          if (byte_cnt == BC_W'(PKT_BYTES - 1)) begin
            release_grant = 1'b1;
            state_nxt     = ST_IDLE;
          end else begin
            bc_inc    = 1'b1;
            tmo_clr   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_full[grant_idx]) begin
          load_enter = 1'b1;
          state_nxt  = ST_LOAD;
        end else if (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_pulse = 1'b1;
          release_grant = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant ownership, packet byte count, idle timer and the transmit byte register.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      grant         <= '0;
      grant_idx     <= '0;
      last_served   <= IDX_W'(NUM_PORTS - 1);
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      uart_tx_value <= '0;
    end else begin
      if (take) begin
        grant     <= pick;
        grant_idx <= pick_idx;
        byte_cnt  <= '0;
      end
      if (release_grant) begin
        grant       <= '0;
        last_served <= grant_idx;
      end
      if (bc_inc) byte_cnt <= byte_cnt + 1'b1;
      if (tmo_clr)                     tmo_cnt <= '0;
      else if (tmo_inc && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
      // Latched on entry to LOAD so the byte is stable during the strobe and after it.
      if (load_enter) uart_tx_value <= hold_data[load_idx];
    end
  end

  // Per-port holding registers; a write landing on the LOAD cycle refills the slot being freed.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      hold_full   <= '0;
      hold_data   <= '0;
      req_overrun <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_write[p]) begin
          if (!hold_full[p] || (state == ST_LOAD && grant_idx == IDX_W'(p))) begin
            hold_data[p] <= req_value[p];
            hold_full[p] <= 1'b1;
          end else begin
            req_overrun[p] <= 1'b1;
          end
        end else if (state == ST_LOAD && grant_idx == IDX_W'(p)) begin
          hold_full[p] <= 1'b0;
        end
      end
    end
  end

endmodule
